// File: rtl/jk_pkg.sv
// Shared command encoding and FSM states for the JK command generator.
package jk_pkg;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/jk_excite.sv
// Excitation for a JK flop: command {j,k} that moves q to target bit b.
module jk_excite
    import jk_pkg::*;
#(
    parameter int MODE = 0
) (
    input  logic       b,
    input  logic       q,
    output logic [1:0] jk
);
    always_comb begin
        jk = JK_HOLD;
        if (b != q) jk = (MODE != 0) ? JK_TOGGLE : (b ? JK_SET : JK_RESET);
    end
endmodule

// File: rtl/jk_cmd_gen.sv
// Serialises a target pattern into a {j,k} command stream, tracking the
// downstream q so matching bits are sent as HOLD.
module jk_cmd_gen
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_init,
    output logic             j,
    output logic             k,
    output logic             ff_rst,
    output logic             q_model,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             cur_bit;
    logic [1:0]       cmd;

    assign cur_bit  = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    jk_excite #(.MODE(MODE)) u_excite (
        .b  (cur_bit),
        .q  (q_model),
        .jk (cmd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            cnt     <= '0;
            j       <= 1'b0;
            k       <= 1'b0;
            ff_rst  <= 1'b0;
            q_model <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    {j, k} <= JK_HOLD;
                    ff_rst <= 1'b0;
                    if (in_valid) begin
                        sreg  <= in_data;
                        cnt   <= CW'(WIDTH);
                        state <= in_init ? ST_CLEAR : ST_SHIFT;
                    end
                end
                ST_CLEAR: begin
                    // One-cycle clear of the downstream flop; model follows.
                    ff_rst  <= 1'b1;
                    {j, k}  <= JK_HOLD;
                    q_model <= 1'b0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {j, k}  <= cmd;
                    q_model <= cur_bit;
                    ff_rst  <= 1'b0;
                    sreg    <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                                : {1'b0, sreg[WIDTH-1:1]};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    {j, k} <= JK_HOLD;
                    ff_rst <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_cmd_gen.sv
// Drives three generator configurations in lockstep against a word-level
// model and a behavioural downstream JK flop.
module tb_jk_cmd_gen;
    localparam int W = 8;
    localparam int N = 3;   // u0: MODE0/MSB, u1: MODE1/MSB, u2: MODE0/LSB

    typedef struct packed {
        logic [1:0] jk;
        logic       ffr;
        logic       qm;
        logic       busy;
        logic       done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_init = 1'b0;
    logic [N-1:0] rdy_o, j_o, k_o, ffr_o, qm_o, busy_o, done_o;
    logic [N-1:0] fq = '0;
    logic         mq [N];
    logic         fl_ok [N];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        jk_cmd_gen #(
            .WIDTH(W), .MODE(g == 1 ? 1 : 0), .MSB_FIRST(g == 2 ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o[g]),
            .in_data(in_data), .in_init(in_init), .j(j_o[g]), .k(k_o[g]),
            .ff_rst(ffr_o[g]), .q_model(qm_o[g]), .busy(busy_o[g]), .done(done_o[g])
        );
    end

    // Downstream JK flops with synchronous active-high clear.
    always @(posedge clk)
        for (int g = 0; g < N; g++) begin
            if (ffr_o[g]) fq[g] <= 1'b0;
            else case ({j_o[g], k_o[g]})
                2'b01:   fq[g] <= 1'b0;
                2'b10:   fq[g] <= 1'b1;
                2'b11:   fq[g] <= ~fq[g];
                default: fq[g] <= fq[g];
            endcase
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge with the DUTs idle; the word is accepted at the next posedge.
    task automatic run_word(input logic [W-1:0] d, input logic init, input logic noisy);
        exp_t seq [N][$];
        exp_t e;
        logic q, b, prev;
        int   n;
        for (int g = 0; g < N; g++) begin
            q = mq[g];
            e = '{jk: 2'b00, ffr: 1'b0, qm: q, busy: 1'b1, done: 1'b0};
            seq[g].push_back(e);
            if (init) begin
                q = 1'b0;
                e = '{jk: 2'b00, ffr: 1'b1, qm: 1'b0, busy: 1'b1, done: 1'b0};
                seq[g].push_back(e);
            end
            for (int i = 0; i < W; i++) begin
                b = (g != 2) ? d[W-1-i] : d[i];
                e.jk   = (b == q) ? 2'b00 : (g == 1) ? 2'b11 : (b ? 2'b10 : 2'b01);
                e.ffr  = 1'b0;
                e.qm   = b;
                e.busy = 1'b1;
                e.done = (i == W - 1);
                seq[g].push_back(e);
                q = b;
            end
            e = '{jk: 2'b00, ffr: 1'b0, qm: q, busy: 1'b0, done: 1'b0};
            seq[g].push_back(e);
            mq[g] = q;
            chk($sformatf("u%0d ready_pre", g), 32'(rdy_o[g]), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_init  = init;
        @(posedge clk);
        n = seq[0].size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (noisy && c < n - 1) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                in_init  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            for (int g = 0; g < N; g++) begin
                e = seq[g][c];
                chk($sformatf("u%0d jk c%0d", g, c), 32'({j_o[g], k_o[g]}), 32'(e.jk));
                chk($sformatf("u%0d ctl c%0d", g, c),
                    32'({ffr_o[g], qm_o[g], busy_o[g], done_o[g], rdy_o[g]}),
                    32'({e.ffr, e.qm, e.busy, e.done, ~e.busy}));
                prev = (c == 0) ? 1'b0 : seq[g][c-1].qm;
                if (fl_ok[g] && c > 0)
                    chk($sformatf("u%0d flop_q c%0d", g, c), 32'(fq[g]), 32'(prev));
                if (e.ffr) fl_ok[g] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            mq[g] = 1'b0;
            fl_ok[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < N; g++)
            chk($sformatf("u%0d reset_state", g),
                32'({j_o[g], k_o[g], ffr_o[g], qm_o[g], busy_o[g], done_o[g]}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_word(8'b1011_0010, 1'b1, 1'b0);   // reference pattern, all three configs
        run_word(8'hFF, 1'b1, 1'b0);          // continuity pair
        run_word(8'h00, 1'b0, 1'b0);
        run_word(8'h5C, 1'b0, 1'b1);          // backpressure during busy
        run_word(8'h01, 1'b1, 1'b0);          // accepted in first idle cycle

        // Reset mid-word: everything clears at once, no done afterwards.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_init  = 1'b0;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < N; g++)
            chk($sformatf("u%0d midreset", g),
                32'({j_o[g], k_o[g], ffr_o[g], qm_o[g], busy_o[g], done_o[g]}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
            mq[g] = 1'b0;
            fl_ok[g] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < N; g++)
                chk($sformatf("u%0d post_reset", g),
                    32'({rdy_o[g], busy_o[g], done_o[g]}), 32'b100);
        end

        run_word(8'h3A, 1'b0, 1'b0);          // no init after reset: continues from q_model=0
        for (int t = 0; t < 20; t++)
            run_word(W'($urandom), 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_cmd_gen.md
Name: jk_cmd_gen

Overview:
- Command-side driver for the team's JK flip-flop.
- Accepts a WIDTH-bit target pattern through a valid/ready handshake and serialises it one bit per clock.
- Emits the {j,k} command stream that makes a downstream JK flop's q follow the pattern.
- Keeps an internal model of the downstream q, so bits already matching q are sent as Hold rather than re-driven.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- MODE, 0, 0 = drive changes with Set/Reset; 1 = drive changes with Toggle.
- MSB_FIRST, 1, 1 = serialise bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  pattern word offered.
- in_ready  out  1  block can accept a word (high only in IDLE).
- in_data  in  WIDTH  target q pattern.
- in_init  in  1  sampled with the word; 1 = clear the downstream flop before bit 0.
- j  out  1  registered J command.
- k  out  1  registered K command.
- ff_rst  out  1  registered active-high synchronous clear for the downstream flop.
- q_model  out  1  downstream q after the currently presented command is applied.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse while the last command of a word is presented.

Behaviour:
- Command encoding is {j,k}: HOLD=00, RESET=01, SET=10, TOGGLE=11.
- Reset (rst=0, any time, including mid-word):
  - state=IDLE, j=k=0, ff_rst=0, q_model=0, done=0, busy=0.
  - Shift register and bit counter are cleared; the in-flight word is discarded.
  - After release, in_ready=1.
  - Downstream consistency is guaranteed only after an in_init word.
- FSM states: IDLE, CLEAR, SHIFT, DONE.
  - IDLE: in_ready=1, {j,k}=HOLD.
    - Accept edge E0 = in_valid && in_ready.
    - At E0, load the shift register, set counter=WIDTH, go to CLEAR if in_init=1, else SHIFT.
  - CLEAR: at its exit edge, ff_rst<=1, {j,k}<=HOLD, q_model<=0, go to SHIFT. ff_rst is high for exactly one cycle.
  - SHIFT: at each edge, let b = current bit. Register:
    - {j,k}<=HOLD if b==q_model.
    - Otherwise {j,k}<=(b ? SET : RESET) when MODE=0, or TOGGLE when MODE=1.
    - q_model<=b; ff_rst<=0; advance shift register; decrement counter.
    - The edge issuing the last bit goes to DONE.
  - DONE: done=1 (decoded from state) while the last command is presented. Exit edge: {j,k}<=HOLD, go to IDLE.
- Latency:
  - Without init: bit i command is presented after edge E0+1+i; done in cycle E0+WIDTH; in_ready again after E0+WIDTH+1.
  - With init: every point is shifted by +1 cycle.
- Word rate: no back-to-back overlap. The next word is accepted in the IDLE cycle after DONE.
- Continuity: q_model persists across words. A word without in_init encodes relative to the last bit of the previous word.
- While busy, in_valid is ignored (in_ready=0). The source holds its word.
- in_data and in_init are sampled only at E0. Later changes have no effect.

Decomposition:
- Package jk_pkg:
  - localparams JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - FSM state encoding.
- One natural sub-module: jk_excite, combinational (b, q, MODE) -> {j,k}, reusable by checkers.
- Bench pairs jk_cmd_gen with the existing JK flop; ff_rst drives its rst.

Test Plan:
1. Reset: pull rst low mid-SHIFT -> j=k=0, ff_rst=0, q_model=0, busy=0 immediately; in_ready=1 after release; no done pulse.
2. MODE=0, MSB_FIRST=1, in_init=1, data 8'b1011_0010:
   - ff_rst pulses 1 cycle.
   - Commands SET,RESET,SET,HOLD,RESET,HOLD,SET,RESET.
   - Downstream q 1,0,1,1,0,0,1,0.
   - done pulses once.
3. MODE=1, same stimulus -> TOGGLE,TOGGLE,TOGGLE,HOLD,TOGGLE,HOLD,TOGGLE,TOGGLE; identical q sequence.
4. Continuity: 8'hFF with init, then 8'h00 without init:
   - First word: SET then 7xHOLD.
   - Second word: RESET then 7xHOLD.
   - Second word accepted the cycle after done.
5. Busy backpressure: in_valid held with new data during SHIFT -> in_ready=0, commands unaffected; word accepted in the first IDLE cycle.
6. MSB_FIRST=0, in_init=1, data 8'h01 -> SET, RESET, then 6xHOLD; final q_model=0.
